multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control unit for the RV32I core; successor to the single-cycle decoder. It sequences each instruction through IF/ID/EX/MEM/WB states, drives per-state datapath enables from the latched instruction register, waits on memory latency, counts retired instructions, and stops on ECALL/EBREAK. It sits between the IR/PC registers and the ALU, register file and memory mux controls in the multi-cycle top.

## Interface
- ALUOP_W, 4, ALU operation code width (≥4; codes zero-extended)
- CNT_W, 32, retired-instruction counter width
- MEM_LAT, 1, memory access cycles per IF/MEM when handshake not compiled (≥1)

- CLK  in  1  clock, rising edge; single clock domain
- RST  in  1  reset, synchronous, active-high
- I_OP  in  32  latched instruction register (stable from ID onward)
- I_BrTaken  in  1  branch-condition result from ALU, valid in EX
- I_MemReady  in  1  memory completion (used only with CTRL_MEM_HANDSHAKE_EN)
- O_PCWrite, O_IRWrite, O_RegWrite, O_MemRead, O_MemWrite  out  1 each  datapath enables
- O_ALUSrcA  out  2  00 rs1, 01 PC, 10 OLD_PC, 11 zero
- O_ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
- O_ALUOp  out  ALUOP_W  ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, SLL 0101, XOR 0110, SRA 0111, SRL 1010, SLTU 1100, BEQ/BNE 1110, BLT-family 1111
- O_WBSel  out  2  00 ALU result, 01 memory data, 10 OLD_PC+4
- O_PCSrc  out  2  00 PC+4, 01 OLD_PC+imm, 10 (rs1+imm)&~1
- O_State  out  3  current state code
- O_NUM_INST  out  CNT_W  retired instruction count
- O_HALT  out  1  sticky halt
- O_Illegal  out  1  one-cycle pulse on undecodable instruction

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6/7 unreachable; if entered, return to IF next cycle.
- IF: O_MemRead=1, ALUSrcA=01/ALUSrcB=10/ADD; on access complete: O_IRWrite=1, O_PCWrite=1, PCSrc=00, OLD_PC latched by datapath, go ID.
- ID: decode I_OP. ECALL (0x00000073)/EBREAK (0x00100073) -> HALT. Undecodable opcode/funct3/funct7 -> O_Illegal pulse, count not incremented, -> IF. Else -> EX.
- EX per class:
  - R-type: A=00,B=00, ALUOp from funct3/funct7 -> WB.
  - I-ALU (incl. SLLI/SRLI/SRAI with funct7 check): A=00,B=01 -> WB.
  - LUI: A=11,B=01,ADD -> WB. AUIPC: A=10,B=01,ADD -> WB.
  - LW/SW: A=00,B=01,ADD -> MEM.
  - Branch: A=00,B=00, ALUOp 1110/1111; if I_BrTaken: O_PCWrite=1, PCSrc=01. Retire -> IF.
  - JAL: O_PCWrite=1, PCSrc=01 -> WB. JALR (funct3=000): PCSrc=10 -> WB.
- MEM: LW O_MemRead=1, complete -> WB. SW O_MemWrite=1, complete -> retire -> IF.
- WB: O_RegWrite=1; WBSel 01 for LW, 10 for JAL/JALR, else 00; retire -> IF.
- Retire: O_NUM_INST += 1 on the cycle leaving the instruction's final state; wraps to 0 at 2^CNT_W.
- HALT: all enables 0; stays until RST; O_HALT=1; ECALL/EBREAK not counted.
- Outputs are combinational from state register, wait counter and I_OP; enables are 0 in any state/class not listed.

## Timing
- Reset (RST high at edge): state<=IF, O_NUM_INST<=0, O_HALT<=0, wait counter<=0. While RST high all enables forced 0, O_Illegal=0. First IF cycle on the edge after RST falls.
- Latency with MEM_LAT=1: branch 3, ALU/LUI/AUIPC/JAL/JALR/SW 4, LW 5 cycles; each IF/MEM adds MEM_LAT-1.
- IF/MEM held MEM_LAT cycles; enables MemRead/MemWrite asserted every held cycle; IRWrite/PCWrite only in the completing cycle.
- RST mid-instruction aborts it: no retire, no write enable in the reset cycle.
- O_Illegal asserted exactly during the ID cycle.

## Configuration
- CTRL_MEM_HANDSHAKE_EN defined: IF/MEM complete on the first cycle I_MemReady=1 (may be same cycle as entry); MEM_LAT ignored; enables held while waiting.
- Not defined: fixed MEM_LAT-cycle counter; I_MemReady ignored.

## Test plan
- RST 2 cycles, then ADDI x1,x0,5 (0x00500093) -> states 0,1,2,4,0; RegWrite=1 only in WB, ALUOp=0000, B=01; O_NUM_INST=1.
- LW 0x0000A103 with MEM_LAT=3 -> IF 3 cycles, MEM 3 cycles, total 9 cycles; WBSel=01 in WB.
- BEQ, I_BrTaken=1 in EX -> PCWrite=1, PCSrc=01 in EX, back to IF, 3 cycles; with I_BrTaken=0 PCWrite=0.
- Opcode 0x0000007F -> O_Illegal one cycle in ID, O_NUM_INST unchanged, next state IF.
- ECALL after 3 retired -> HALT, O_HALT=1 held 20 cycles, O_NUM_INST=3; RST clears to 0.
- Handshake build: I_MemReady low 4 cycles in IF -> MemRead held, IRWrite only on ready cycle; RST asserted in MEM of SW -> MemWrite 0, state IF, no retire.

Source files
------------

// File: rtl/multicycle_control.sv
// RV32I multi-cycle control unit: sequences IF/ID/EX/MEM/WB/HALT and drives datapath enables.
// Define CTRL_MEM_HANDSHAKE_EN to finish IF/MEM on I_MemReady instead of a MEM_LAT-cycle counter.
module multicycle_control #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        I_OP,
    input  logic               I_BrTaken,
    input  logic               I_MemReady,
    output logic               O_PCWrite,
    output logic               O_IRWrite,
    output logic               O_RegWrite,
    output logic               O_MemRead,
    output logic               O_MemWrite,
    output logic [1:0]         O_ALUSrcA,
    output logic [1:0]         O_ALUSrcB,
    output logic [ALUOP_W-1:0] O_ALUOp,
    output logic [1:0]         O_WBSel,
    output logic [1:0]         O_PCSrc,
    output logic [2:0]         O_State,
    output logic [CNT_W-1:0]   O_NUM_INST,
    output logic               O_HALT,
    output logic               O_Illegal
);

    localparam logic [3:0] AluAdd = 4'b0000, AluSub = 4'b0001, AluAnd = 4'b0010, AluOr = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0100, AluSll = 4'b0101, AluXor = 4'b0110, AluSra = 4'b0111;
    localparam logic [3:0] AluSrl = 4'b1010, AluSltu = 4'b1100, AluBeq = 4'b1110, AluBlt = 4'b1111;

    typedef enum logic [2:0] {
        StIf = 3'd0, StId = 3'd1, StEx = 3'd2, StMem = 3'd3, StWb = 3'd4, StHalt = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsIll, ClsR, ClsIAlu, ClsLui, ClsAuipc, ClsLw, ClsSw, ClsBr, ClsJal, ClsJalr, ClsSys
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls;
    logic [3:0]       alu_dec, alu_op;
    logic [CNT_W-1:0] num_q;
    logic             retire, mem_done;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;

    assign opcode = I_OP[6:0];
    assign funct3 = I_OP[14:12];
    assign funct7 = I_OP[31:25];

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] r;
        unique case (f3)
            3'b000:  r = AluAdd;
            3'b001:  r = AluSll;
            3'b010:  r = AluSlt;
            3'b011:  r = AluSltu;
            3'b100:  r = AluXor;
            3'b101:  r = AluSrl;
            3'b110:  r = AluOr;
            default: r = AluAnd;
        endcase
        return r;
    endfunction

    always_comb begin
        cls     = ClsIll;
        alu_dec = AluAdd;
        unique case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    cls     = ClsR;
                    alu_dec = base_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    cls     = ClsR;
                    alu_dec = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    cls     = ClsR;
                    alu_dec = AluSra;
                end
            end
            7'b0010011: begin
                alu_dec = base_op(funct3);
                // Only the shift immediates carry a funct7 that must be checked.
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) cls = ClsIAlu;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000) begin
                        cls = ClsIAlu;
                    end else if (funct7 == 7'b0100000) begin
                        cls     = ClsIAlu;
                        alu_dec = AluSra;
                    end
                end else begin
                    cls = ClsIAlu;
                end
            end
            7'b0110111: cls = ClsLui;
            7'b0010111: cls = ClsAuipc;
            7'b0000011: if (funct3 == 3'b010) cls = ClsLw;
            7'b0100011: if (funct3 == 3'b010) cls = ClsSw;
            7'b1100011: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) cls = ClsBr;
                alu_dec = funct3[2] ? AluBlt : AluBeq;
            end
            7'b1101111: cls = ClsJal;
            7'b1100111: if (funct3 == 3'b000) cls = ClsJalr;
            7'b1110011: if (I_OP == 32'h0000_0073 || I_OP == 32'h0010_0073) cls = ClsSys;
            default:    cls = ClsIll;
        endcase
    end

`ifdef CTRL_MEM_HANDSHAKE_EN
    assign mem_done = I_MemReady;
`else
    localparam int unsigned WaitW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [WaitW-1:0] wait_q, wait_d;
    logic             unused_mem_ready;

    assign unused_mem_ready = I_MemReady;
    assign mem_done         = (wait_q == WaitW'(MEM_LAT - 1));

    always_comb begin
        wait_d = '0;
        if ((state_q == StIf || state_q == StMem) && !mem_done) wait_d = wait_q + WaitW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        O_PCWrite  = 1'b0;
        O_IRWrite  = 1'b0;
        O_RegWrite = 1'b0;
        O_MemRead  = 1'b0;
        O_MemWrite = 1'b0;
        O_ALUSrcA  = 2'b00;
        O_ALUSrcB  = 2'b00;
        alu_op     = AluAdd;
        O_WBSel    = 2'b00;
        O_PCSrc    = 2'b00;
        O_Illegal  = 1'b0;
        case (state_q)
            StIf: begin
                O_MemRead = 1'b1;
                O_ALUSrcA = 2'b01;
                O_ALUSrcB = 2'b10;
                if (mem_done) begin
                    O_IRWrite = 1'b1;
                    O_PCWrite = 1'b1;
                    state_d   = StId;
                end
            end
            StId: begin
                if (cls == ClsSys) begin
                    state_d = StHalt;
                end else if (cls == ClsIll) begin
                    O_Illegal = 1'b1;
                    state_d   = StIf;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                state_d = StWb;
                unique case (cls)
                    ClsR:     alu_op = alu_dec;
                    ClsIAlu:  begin O_ALUSrcB = 2'b01; alu_op = alu_dec; end
                    ClsLui:   begin O_ALUSrcA = 2'b11; O_ALUSrcB = 2'b01; end
                    ClsAuipc: begin O_ALUSrcA = 2'b10; O_ALUSrcB = 2'b01; end
                    ClsLw, ClsSw: begin
                        O_ALUSrcB = 2'b01;
                        state_d   = StMem;
                    end
                    ClsBr: begin
                        alu_op  = alu_dec;
                        retire  = 1'b1;
                        state_d = StIf;
                        if (I_BrTaken) begin
                            O_PCWrite = 1'b1;
                            O_PCSrc   = 2'b01;
                        end
                    end
                    ClsJal:  begin O_PCWrite = 1'b1; O_PCSrc = 2'b01; end
                    ClsJalr: begin O_PCWrite = 1'b1; O_PCSrc = 2'b10; end
                    default: state_d = StIf;
                endcase
            end
            StMem: begin
                O_MemRead  = (cls == ClsLw);
                O_MemWrite = (cls == ClsSw);
                if (mem_done) begin
                    if (cls == ClsLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = (cls == ClsSw);
                        state_d = StIf;
                    end
                end
            end
            StWb: begin
                O_RegWrite = 1'b1;
                O_WBSel    = (cls == ClsLw) ? 2'b01 :
                             (cls == ClsJal || cls == ClsJalr) ? 2'b10 : 2'b00;
                retire     = 1'b1;
                state_d    = StIf;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIf;
        endcase
        // Reset aborts the current instruction: no writes, no retire.
        if (RST) begin
            retire     = 1'b0;
            O_PCWrite  = 1'b0;
            O_IRWrite  = 1'b0;
            O_RegWrite = 1'b0;
            O_MemRead  = 1'b0;
            O_MemWrite = 1'b0;
            O_Illegal  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIf;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) num_q <= num_q + CNT_W'(1);
        end
    end

    assign O_ALUOp    = ALUOP_W'(alu_op);
    assign O_State    = state_q;
    assign O_NUM_INST = num_q;
    assign O_HALT     = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, directed corner sequences and a randomized
// instruction stream checked against a per-instruction cycle model, on two parameterisations.
module tb_multicycle_control;

    localparam int unsigned LAT1 = 3;
`ifdef CTRL_MEM_HANDSHAKE_EN
    localparam int unsigned EFF1 = 1;
`else
    localparam int unsigned EFF1 = LAT1;
`endif
    localparam int MIll = 0, MR = 1, MI = 2, MLui = 3, MAuipc = 4, MLw = 5, MSw = 6, MBr = 7,
                   MJal = 8, MJalr = 9, MSys = 10;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rw, mr, mw;
        logic [1:0] a, b;
        logic [3:0] aop;
        logic [1:0] wb, pcs;
        logic       ill, halt;
    } cyc_t;

    typedef struct {
        logic [31:0] op;
        logic        br;
        int          cyc1, cyc3;
        logic        ill, ret, rw, chk;
        logic [3:0]  aop;
        logic [1:0]  a, b, wb;
        logic        pcw;
        logic [1:0]  pcs;
    } vec_t;

    logic            clk = 1'b0;
    logic [1:0]      rst, br, rdy;
    logic [1:0][31:0] op;
    logic [1:0]      pcw, irw, rw, mr, mw, halt, ill;
    logic [1:0][1:0] asa, asb, wbs, pcs;
    logic [1:0][3:0] aop;
    logic [1:0][2:0] st;
    logic [31:0]     num0;
    logic [3:0]      num1;

    int          checks = 0, errors = 0;
    logic [31:0] mcnt[2];
    cyc_t        expq[$];
    vec_t        vecs[15];
    logic [3:0]  base_tab[8] = '{4'h0, 4'h5, 4'h4, 4'hC, 4'h6, 4'hA, 4'h3, 4'h2};

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(4), .CNT_W(32), .MEM_LAT(1)) u_dut0 (
        .CLK(clk), .RST(rst[0]), .I_OP(op[0]), .I_BrTaken(br[0]), .I_MemReady(rdy[0]),
        .O_PCWrite(pcw[0]), .O_IRWrite(irw[0]), .O_RegWrite(rw[0]), .O_MemRead(mr[0]),
        .O_MemWrite(mw[0]), .O_ALUSrcA(asa[0]), .O_ALUSrcB(asb[0]), .O_ALUOp(aop[0]),
        .O_WBSel(wbs[0]), .O_PCSrc(pcs[0]), .O_State(st[0]), .O_NUM_INST(num0),
        .O_HALT(halt[0]), .O_Illegal(ill[0])
    );

    multicycle_control #(.ALUOP_W(4), .CNT_W(4), .MEM_LAT(LAT1)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .I_OP(op[1]), .I_BrTaken(br[1]), .I_MemReady(rdy[1]),
        .O_PCWrite(pcw[1]), .O_IRWrite(irw[1]), .O_RegWrite(rw[1]), .O_MemRead(mr[1]),
        .O_MemWrite(mw[1]), .O_ALUSrcA(asa[1]), .O_ALUSrcB(asb[1]), .O_ALUOp(aop[1]),
        .O_WBSel(wbs[1]), .O_PCSrc(pcs[1]), .O_State(st[1]), .O_NUM_INST(num1),
        .O_HALT(halt[1]), .O_Illegal(ill[1])
    );

    function automatic cyc_t obs(input int d);
        cyc_t c;
        c.st = st[d]; c.pcw = pcw[d]; c.irw = irw[d]; c.rw = rw[d]; c.mr = mr[d];
        c.mw = mw[d]; c.a = asa[d]; c.b = asb[d]; c.aop = aop[d]; c.wb = wbs[d];
        c.pcs = pcs[d]; c.ill = ill[d]; c.halt = halt[d];
        return c;
    endfunction

    function automatic logic [31:0] num_of(input int d);
        return (d == 0) ? num0 : {28'd0, num1};
    endfunction

    function automatic logic [31:0] mask_of(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : int'(EFF1);
    endfunction

    function automatic cyc_t mk(input logic [2:0] s);
        cyc_t c = '0;
        c.st = s;
        return c;
    endfunction

    function automatic vec_t mkv(input logic [31:0] o, input logic b, input int c1, input int c3,
                                 input logic il, input logic rt, input logic w, input logic ck,
                                 input logic [3:0] ao, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [1:0] ws, input logic pw, input logic [1:0] ps);
        vec_t v;
        v.op = o; v.br = b; v.cyc1 = c1; v.cyc3 = c3; v.ill = il; v.ret = rt; v.rw = w;
        v.chk = ck; v.aop = ao; v.a = sa; v.b = sb; v.wb = ws; v.pcw = pw; v.pcs = ps;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Classification straight from the ISA rules the unit must honour.
    task automatic mdecode(input logic [31:0] w, output int cls, output logic [3:0] a);
        logic [6:0] oc = w[6:0];
        logic [6:0] f7 = w[31:25];
        logic [2:0] f3 = w[14:12];
        cls = MIll;
        a   = 4'h0;
        case (oc)
            7'h33: begin
                if (f7 == 7'h00)                   begin cls = MR; a = base_tab[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin cls = MR; a = 4'h1; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin cls = MR; a = 4'h7; end
            end
            7'h13: begin
                if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)))
                begin
                    cls = MI;
                    a   = (f3 == 3'd5 && f7 == 7'h20) ? 4'h7 : base_tab[f3];
                end
            end
            7'h37: cls = MLui;
            7'h17: cls = MAuipc;
            7'h03: if (f3 == 3'd2) cls = MLw;
            7'h23: if (f3 == 3'd2) cls = MSw;
            7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin cls = MBr; a = (f3 >= 3'd4) ? 4'hF : 4'hE; end
            7'h6F: cls = MJal;
            7'h67: if (f3 == 3'd0) cls = MJal + 1;
            7'h73: if (w == 32'h0000_0073 || w == 32'h0010_0073) cls = MSys;
            default: ;
        endcase
    endtask

    // Expected per-cycle trace of one instruction; returns whether it retires.
    task automatic build(input int lat, input logic [31:0] w, input logic b, output logic ret);
        int         cls;
        logic [3:0] a;
        cyc_t       c;
        mdecode(w, cls, a);
        expq.delete();
        ret = 1'b0;
        for (int i = 0; i < lat; i++) begin
            c = mk(3'd0); c.mr = 1'b1; c.a = 2'b01; c.b = 2'b10;
            if (i == lat - 1) begin c.irw = 1'b1; c.pcw = 1'b1; end
            expq.push_back(c);
        end
        c = mk(3'd1); c.ill = (cls == MIll);
        expq.push_back(c);
        if (cls == MSys) begin
            c = mk(3'd5); c.halt = 1'b1;
            repeat (20) expq.push_back(c);
            return;
        end
        if (cls == MIll) return;
        ret = 1'b1;
        c = mk(3'd2);
        case (cls)
            MR:     c.aop = a;
            MI:     begin c.b = 2'b01; c.aop = a; end
            MLui:   begin c.a = 2'b11; c.b = 2'b01; end
            MAuipc: begin c.a = 2'b10; c.b = 2'b01; end
            MLw, MSw: c.b = 2'b01;
            MBr:    begin c.aop = a; if (b) begin c.pcw = 1'b1; c.pcs = 2'b01; end end
            MJal:   begin c.pcw = 1'b1; c.pcs = 2'b01; end
            default: begin c.pcw = 1'b1; c.pcs = 2'b10; end
        endcase
        expq.push_back(c);
        if (cls == MBr) return;
        if (cls == MLw || cls == MSw) begin
            for (int i = 0; i < lat; i++) begin
                c = mk(3'd3); c.mr = (cls == MLw); c.mw = (cls == MSw);
                expq.push_back(c);
            end
            if (cls == MSw) return;
        end
        c = mk(3'd4); c.rw = 1'b1;
        c.wb = (cls == MLw) ? 2'b01 : (cls == MJal || cls == MJalr) ? 2'b10 : 2'b00;
        expq.push_back(c);
    endtask

    task automatic do_reset(input int d, input int n);
        cyc_t c;
        rst[d] = 1'b1;
        repeat (n) begin
            @(negedge clk); #1;
            c = obs(d);
            check($sformatf("d%0d_reset_ctl", d), {c.st, c.pcw, c.irw, c.rw, c.mr, c.mw, c.ill,
                  c.halt}, 10'd0);
            check($sformatf("d%0d_reset_num", d), num_of(d), 32'd0);
        end
        rst[d]  = 1'b0;
        mcnt[d] = 32'd0;
    endtask

    task automatic run_model(input int d, input logic [31:0] w, input logic b);
        logic ret;
        op[d] = w;
        br[d] = b;
        build(lat_of(d), w, b, ret);
        foreach (expq[i]) begin
            #1;
            check($sformatf("d%0d_op%08h_cyc%0d", d, w, i), obs(d), expq[i]);
            @(negedge clk);
        end
        if (ret) mcnt[d] = (mcnt[d] + 32'd1) & mask_of(d);
        check($sformatf("d%0d_op%08h_num", d, w), num_of(d), mcnt[d]);
    endtask

    task automatic run_vec(input int d, input int k);
        vec_t        v = vecs[k];
        cyc_t        c, ex = '0;
        int          n = 0, pulses = 0, rwc = 0;
        logic        seen_id = 1'b0;
        logic [1:0]  wb = 2'b00;
        logic [31:0] start = num_of(d);
        op[d] = v.op;
        br[d] = v.br;
        forever begin
            #1;
            c = obs(d);
            if (c.st == 3'd0 && seen_id) break;
            if (n >= 40) begin timeout($sformatf("d%0d_vec%0d", d, k)); break; end
            if (c.st == 3'd1) seen_id = 1'b1;
            if (c.st == 3'd2) ex = c;
            if (c.st == 3'd4) begin rwc++; wb = c.wb; end
            pulses += int'(c.ill);
            n++;
            @(negedge clk);
        end
        check($sformatf("d%0d_vec%0d_cycles", d, k), n, (lat_of(d) == 1) ? v.cyc1 : v.cyc3);
        check($sformatf("d%0d_vec%0d_illegal", d, k), pulses, v.ill);
        check($sformatf("d%0d_vec%0d_regwrite", d, k), rwc, v.rw);
        check($sformatf("d%0d_vec%0d_wbsel", d, k), wb, v.wb);
        check($sformatf("d%0d_vec%0d_ex_pc", d, k), {ex.pcw, ex.pcs}, {v.pcw, v.pcs});
        if (v.chk) check($sformatf("d%0d_vec%0d_ex_alu", d, k), {ex.aop, ex.a, ex.b},
                         {v.aop, v.a, v.b});
        check($sformatf("d%0d_vec%0d_retire", d, k), (num_of(d) - start) & mask_of(d), v.ret);
        mcnt[d] = num_of(d);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w   = $urandom;
        int unsigned sel = $urandom_range(0, 11);
        logic        odd = ($urandom_range(0, 3) == 0);
        case (sel)
            0:  begin w[6:0] = 7'h33; if (!odd) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            1:  begin w[6:0] = 7'h13; if (!odd) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            2:  w[6:0] = 7'h37;
            3:  w[6:0] = 7'h17;
            4:  begin w[6:0] = 7'h03; if (!odd) w[14:12] = 3'd2; end
            5:  begin w[6:0] = 7'h23; if (!odd) w[14:12] = 3'd2; end
            6:  w[6:0] = 7'h63;
            7:  w[6:0] = 7'h6F;
            8:  begin w[6:0] = 7'h67; if (!odd) w[14:12] = 3'd0; end
            default: ;
        endcase
        if (w == 32'h0000_0073 || w == 32'h0010_0073) w = 32'h0000_0013;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cyc_t c;
        int   n;
        rst = 2'b11;
        br  = 2'b00;
        op  = {32'h0000_0013, 32'h0000_0013};
`ifdef CTRL_MEM_HANDSHAKE_EN
        rdy = 2'b11;
`else
        rdy = 2'b00;
`endif
        vecs[0]  = mkv(32'h0050_0093, 0, 4, 6, 0, 1, 1, 1, 4'h0, 2'd0, 2'd1, 2'd0, 0, 2'd0);
        vecs[1]  = mkv(32'h0000_A103, 0, 5, 9, 0, 1, 1, 1, 4'h0, 2'd0, 2'd1, 2'd1, 0, 2'd0);
        vecs[2]  = mkv(32'h0000_0463, 1, 3, 5, 0, 1, 0, 1, 4'hE, 2'd0, 2'd0, 2'd0, 1, 2'd1);
        vecs[3]  = mkv(32'h0000_0463, 0, 3, 5, 0, 1, 0, 1, 4'hE, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        vecs[4]  = mkv(32'h4020_81B3, 0, 4, 6, 0, 1, 1, 1, 4'h1, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        vecs[5]  = mkv(32'h0020_A023, 0, 4, 8, 0, 1, 0, 1, 4'h0, 2'd0, 2'd1, 2'd0, 0, 2'd0);
        vecs[6]  = mkv(32'h1234_52B7, 0, 4, 6, 0, 1, 1, 1, 4'h0, 2'd3, 2'd1, 2'd0, 0, 2'd0);
        vecs[7]  = mkv(32'h1234_5297, 0, 4, 6, 0, 1, 1, 1, 4'h0, 2'd2, 2'd1, 2'd0, 0, 2'd0);
        vecs[8]  = mkv(32'h0100_00EF, 0, 4, 6, 0, 1, 1, 0, 4'h0, 2'd0, 2'd0, 2'd2, 1, 2'd1);
        vecs[9]  = mkv(32'h0001_00E7, 0, 4, 6, 0, 1, 1, 0, 4'h0, 2'd0, 2'd0, 2'd2, 1, 2'd2);
        vecs[10] = mkv(32'h4030_D093, 0, 4, 6, 0, 1, 1, 1, 4'h7, 2'd0, 2'd1, 2'd0, 0, 2'd0);
        vecs[11] = mkv(32'h0000_007F, 0, 2, 4, 1, 0, 0, 0, 4'h0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        vecs[12] = mkv(32'h4010_9093, 0, 2, 4, 1, 0, 0, 0, 4'h0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        vecs[13] = mkv(32'h0000_6463, 1, 3, 5, 0, 1, 0, 1, 4'hF, 2'd0, 2'd0, 2'd0, 1, 2'd1);
        vecs[14] = mkv(32'h0020_B1B3, 0, 4, 6, 0, 1, 1, 1, 4'hC, 2'd0, 2'd0, 2'd0, 0, 2'd0);

        for (int d = 0; d < 2; d++) begin
            do_reset(d, 2);
            for (int k = 0; k < 15; k++) run_vec(d, k);
        end

        // ECALL after three retirements halts with the count frozen; reset clears it.
        do_reset(0, 2);
        repeat (3) run_model(0, 32'h0050_0093, 1'b0);
        run_model(0, 32'h0000_0073, 1'b0);
        do_reset(0, 1);
        do_reset(1, 1);
        run_model(1, 32'h0050_0093, 1'b0);
        run_model(1, 32'h0010_0073, 1'b0);
        do_reset(1, 1);

`ifdef CTRL_MEM_HANDSHAKE_EN
        // Fetch stalled on memory: read held, IR/PC writes only on the ready cycle.
        rdy[0] = 1'b0;
        op[0]  = 32'h0050_0093;
        repeat (4) begin
            #1;
            c = obs(0);
            check("hs_if_wait", {c.st, c.mr, c.irw, c.pcw}, {3'd0, 3'b100});
            @(negedge clk);
        end
        rdy[0] = 1'b1;
        #1;
        c = obs(0);
        check("hs_if_ready", {c.st, c.mr, c.irw, c.pcw}, {3'd0, 3'b111});
        @(negedge clk);
        #1;
        check("hs_id_next", st[0], 3'd1);
        n = 0;
        while (st[0] != 3'd0 && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout("hs_finish");
        check("hs_num", num0, 32'd1);
        do_reset(0, 1);
`endif

        // Reset landing in the MEM cycle of a store aborts it without a write or retire.
        op[1] = 32'h0020_A023;
        n = 0;
        forever begin
            #1;
            if (st[1] == 3'd3) break;
            if (n >= 20) begin timeout("sw_reach_mem"); break; end
            n++;
            @(negedge clk);
        end
        check("sw_mem_write", mw[1], 1'b1);
        rst[1] = 1'b1;
        #1;
        check("sw_rst_enables", {mw[1], mr[1], pcw[1], irw[1], rw[1]}, 5'd0);
        @(negedge clk);
        #1;
        check("sw_rst_state", st[1], 3'd0);
        check("sw_rst_num", num1, 4'd0);
        rst[1]  = 1'b0;
        mcnt[1] = 32'd0;

        for (int d = 0; d < 2; d++) begin
            do_reset(d, 1);
            repeat (120) run_model(d, rand_instr(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
